// File: rtl/bus_dmx_pkg.sv
// -----------------------------------------------------------------------------
// bus_dmx_pkg
// Shared types and constants for the bus_dmx_ctrl sequencing controller and
// its FIFO.
//   NPORT   : number of demux outputs (one-hot strobe width)
//   ADDR_W  : destination / demux select width
//   DATA_W  : payload width carried by a FIFO entry (the controller's N)
//   state_t : controller FSM states (IDLE = nothing buffered, SEND = head shown)
//   entry_t : FIFO entry {dst, data}
// -----------------------------------------------------------------------------
package bus_dmx_pkg;

   localparam int NPORT  = 8;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] dst;
      logic [DATA_W-1:0] data;
   } entry_t;

   // One-hot strobe for a destination index.
   function automatic logic [NPORT-1:0] onehot(input logic [ADDR_W-1:0] sel);
      logic [NPORT-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/bus_dmx_ctrl_if.sv
// -----------------------------------------------------------------------------
// bus_dmx_ctrl_if
// Producer handshake and demux-side signals of bus_dmx_ctrl.
//   in_valid/in_ready/in_dst/in_data : producer word handshake
//   addr/X                           : demux select and data input
//   out_valid/out_ready              : one-hot strobe and per-consumer accept
// Modports:
//   slave  : the controller's view
//   master : the environment's view (producer + consumers)
// -----------------------------------------------------------------------------
interface bus_dmx_ctrl_if
   import bus_dmx_pkg::*;
#(
   parameter int N = DATA_W
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_dst;
   logic [N-1:0]      in_data;
   logic [ADDR_W-1:0] addr;
   logic [N-1:0]      X;
   logic [NPORT-1:0]  out_valid;
   logic [NPORT-1:0]  out_ready;

   modport slave (
      input  in_valid, in_dst, in_data, out_ready,
      output in_ready, addr, X, out_valid
   );

   modport master (
      output in_valid, in_dst, in_data, out_ready,
      input  in_ready, addr, X, out_valid
   );
endinterface

// File: rtl/bus_dmx_fifo.sv
// -----------------------------------------------------------------------------
// bus_dmx_fifo
// Synchronous DEPTH-entry FIFO of entry_t words with a fall-through head.
//   clk, rst : clock, synchronous active-high reset (pointers only)
//   push/din : write din when not full
//   pop      : retire the head when not empty
//   head     : current oldest entry (valid while !empty)
//   full     : DEPTH entries held
//   empty    : no entries held
//   last     : exactly one entry held
// Pointers carry one extra bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module bus_dmx_fifo
   import bus_dmx_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  entry_t din,
   input  logic   pop,
   output entry_t head,
   output logic   full,
   output logic   empty,
   output logic   last
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   entry_t         mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign last  = ((wr_ptr - rd_ptr) == (PTR_W+1)'(1));
   assign head  = mem[rd_ptr[PTR_W-1:0]];

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers alone
   // define which entries are meaningful, and an unreset array maps to RAM.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[PTR_W-1:0]] <= din;
   end
endmodule

// File: rtl/bus_dmx_ctrl.sv
// -----------------------------------------------------------------------------
// bus_dmx_ctrl
// Sequencing controller for the 1-to-8 bus demultiplexer bus_dmx_1_8.
// Buffers tagged words from one producer and presents the FIFO head to the
// demux, strobing only the selected consumer; a word retires when that
// consumer accepts it.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : bus_dmx_ctrl_if.slave (in_* handshake, addr/X, out_valid/ready)
//   busy      : a word is being presented (state == SEND)
//   drop      : one-cycle pulse when the head is discarded after a stall
//   drop_dst  : destination of the dropped word while drop = 1, else 0
// Configuration macro: BUS_DMX_CTRL_TIMEOUT_EN
//   defined   : a head stalled for TIMEOUT cycles is dropped on the next
//               stalled cycle (the (TIMEOUT+1)-th presentation cycle)
//   undefined : stalls hold forever, drop/drop_dst tied to 0
// -----------------------------------------------------------------------------
module bus_dmx_ctrl
   import bus_dmx_pkg::*;
#(
   parameter int N       = DATA_W,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
)(
   input  logic              clk,
   input  logic              rst,
   bus_dmx_ctrl_if.slave     bus,
   output logic              busy,
   output logic              drop,
   output logic [ADDR_W-1:0] drop_dst
);
   state_t state;
   entry_t head;
   entry_t din;
   logic   full;
   logic   empty;
   logic   last;
   logic   push;
   logic   pop;
   logic   xfer;
   logic   drop_i;

   // No pass-through when full: a pop in the same cycle does not free a slot.
   assign bus.in_ready = !rst && !full;
   assign push         = bus.in_valid && bus.in_ready;
   assign din          = '{dst: bus.in_dst, data: bus.in_data};

   bus_dmx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .head  (head),
      .full  (full),
      .empty (empty),
      .last  (last)
   );

   // Demux-side outputs depend only on registered state and the stored head.
   assign busy          = (state == SEND);
   assign bus.addr      = busy ? head.dst  : '0;
   assign bus.X         = busy ? head.data : '0;
   assign bus.out_valid = busy ? onehot(head.dst) : '0;

   // Only the selected consumer's ready bit matters.
   assign xfer = busy && bus.out_ready[head.dst];
   assign pop  = (xfer || drop_i) && !empty;

`ifdef BUS_DMX_CTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] stall_cnt;

   // A transfer in the limit cycle wins because drop requires ready low.
   assign drop_i = busy && !bus.out_ready[head.dst] &&
                   (stall_cnt == CNT_W'(TIMEOUT));

   // Cleared on every pop so each newly presented head starts from zero.
   always_ff @(posedge clk) begin
      if (rst || !busy || pop)
         stall_cnt <= '0;
      else
         stall_cnt <= stall_cnt + CNT_W'(1);
   end
`else
   logic unused_timeout;

   assign drop_i         = 1'b0;
   assign unused_timeout = (TIMEOUT > 0);
`endif

   assign drop     = drop_i;
   assign drop_dst = drop_i ? head.dst : '0;

   // SEND is left only when the last buffered word retires with no refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (push) state <= SEND;
            SEND:    if (pop && !push && last) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_dmx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_dmx_ctrl
// Self-checking bench for bus_dmx_ctrl. The stimulus side pushes every
// accepted word into a scoreboard queue; an independent monitor on the falling
// edge compares the DUT against the queue head (in-order delivery, one-hot
// strobe, flow control, stall drops when BUS_DMX_CTRL_TIMEOUT_EN is defined).
// -----------------------------------------------------------------------------
module tb_bus_dmx_ctrl;
   import bus_dmx_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              busy;
   logic              drop;
   logic [ADDR_W-1:0] drop_dst;

   bus_dmx_ctrl_if #(.N(DATA_W)) bus ();

   bus_dmx_ctrl #(
      .N       (DATA_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .drop     (drop),
      .drop_dst (drop_dst)
   );

   always #5 clk = ~clk;

   entry_t sb[$];
   entry_t h;
   int     n_vec     = 0;
   int     n_miss    = 0;
   int     stall     = 0;
   int     delivered = 0;
   int     dropped   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference: the queue head is what must be on the bus; a word leaves the
   // queue when its own consumer is ready, or after TIMEOUT stalled cycles.
   always @(negedge clk) begin : monitor
      if (rst) begin
         check("in_ready_rst", 32'(bus.in_ready), 32'd0);
         sb.delete();
         stall = 0;
      end else begin
         check("in_ready", 32'(bus.in_ready), 32'(sb.size() < DEPTH));
         if (sb.size() == 0) begin
            check("idle_out_valid", 32'(bus.out_valid), 32'd0);
            check("idle_addr", 32'(bus.addr), 32'd0);
            check("idle_x", 32'(bus.X), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_drop", 32'(drop), 32'd0);
         end else begin
            h = sb[0];
            check("out_valid", 32'(bus.out_valid), 32'd1 << h.dst);
            check("addr", 32'(bus.addr), 32'(h.dst));
            check("x", 32'(bus.X), 32'(h.data));
            check("busy", 32'(busy), 32'd1);
            if (bus.out_ready[h.dst]) begin
               check("drop_on_xfer", 32'(drop), 32'd0);
               void'(sb.pop_front());
               stall = 0;
               delivered++;
            end else begin
`ifdef BUS_DMX_CTRL_TIMEOUT_EN
               if (stall == TIMEOUT) begin
                  check("drop", 32'(drop), 32'd1);
                  check("drop_dst", 32'(drop_dst), 32'(h.dst));
                  void'(sb.pop_front());
                  stall = 0;
                  dropped++;
               end else begin
                  check("no_drop", 32'(drop), 32'd0);
                  stall++;
               end
`else
               check("no_drop", 32'(drop), 32'd0);
               check("no_drop_dst", 32'(drop_dst), 32'd0);
`endif
            end
         end
      end
   end

   // One cycle: drive at posedge+1, decide acceptance mid-cycle, record the
   // word at the edge that actually stores it.
   task automatic cyc(input logic v, input logic [ADDR_W-1:0] d,
                      input logic [DATA_W-1:0] x, input logic [NPORT-1:0] r);
      logic acc;
      bus.in_valid  = v;
      bus.in_dst    = d;
      bus.in_data   = x;
      bus.out_ready = r;
      @(negedge clk);
      acc = v && bus.in_ready;
      @(posedge clk);
      if (acc) sb.push_back('{dst: d, data: x});
      #1;
   endtask

   task automatic idle(input int n, input logic [NPORT-1:0] r);
      repeat (n) cyc(1'b0, '0, '0, r);
   endtask

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stimulus
      int d0;
      int budget;
      bus.in_valid  = 1'b0;
      bus.in_dst    = '0;
      bus.in_data   = '0;
      bus.out_ready = '0;
      rst           = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Single word straight through.
      cyc(1'b1, 3'd5, 8'hA5, 8'hFF);
      idle(3, 8'hFF);

      // Fill, refused push during a pop, then drain in order.
      for (int i = 0; i < 4; i++) cyc(1'b1, 3'(i), 8'($urandom), 8'h00);
      cyc(1'b1, 3'd7, 8'h77, 8'hFF);
      idle(6, 8'hFF);

      // Selected consumer not ready: other ready bits must not pop the head.
      cyc(1'b1, 3'd2, 8'h3C, 8'hFB);
      idle(5, 8'hFB);
      idle(2, 8'hFF);

      // Long stall on a blocked head.
      d0 = dropped;
      cyc(1'b1, 3'd6, 8'h66, 8'h00);
      cyc(1'b1, 3'd1, 8'h11, 8'h00);
      idle(100, 8'h00);
      idle(3, 8'hFF);
`ifdef BUS_DMX_CTRL_TIMEOUT_EN
      check("drop_count", 32'(dropped - d0), 32'd2);
`else
      check("drop_count", 32'(dropped - d0), 32'd0);
`endif

      // Reset with three words buffered: none may ever appear.
      for (int i = 0; i < 3; i++) cyc(1'b1, 3'(i + 3), 8'($urandom), 8'h00);
      d0  = delivered;
      rst = 1'b1;
      idle(1, 8'h00);
      rst = 1'b0;
      idle(20, 8'hFF);
      check("post_rst_delivered", 32'(delivered - d0), 32'd0);

      // Randomised traffic with occasional full back-pressure bursts.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 3)
            idle(int'($urandom_range(1, 20)), 8'h00);
         cyc(1'($urandom_range(0, 99) < 60), 3'($urandom),
             8'($urandom), 8'($urandom));
      end

      // Drain with a bounded budget.
      budget = 0;
      while (sb.size() > 0 && budget < 200) begin
         idle(1, 8'hFF);
         budget++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
      idle(2, 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
